// File: rtl/line_mem_pkg.sv
// Shared types and sizing for the line-granular backing-store controller.
// Imported by line_mem_array and line_mem_ctrl.
package line_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int LINE_W_DEF = 20;
    localparam int LINE_DEPTH = 512;
    localparam int LINE_IDX_W = ADDR_W_DEF - 1;
    localparam int CNT_W      = 4;   // holds LAT-1 for LAT up to 15
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/line_mem_array.sv
// Single-port synchronous line storage with a registered read port.
// Contents start at zero and survive rst_n; only the read register is reset.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int IDX_W  = LINE_IDX_W,
    parameter int LINE_W = LINE_W_DEF,
    parameter int DEPTH  = LINE_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    // NOTE: the storage itself has no reset branch -- a reset port on a RAM
    // blocks block-RAM inference; the declaration value gives time-zero zeros.
    logic [LINE_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// Fixed-latency line memory controller on a shared tristate line bus.
// Define LINE_MEM_STATS_EN to build the saturating read/write completion counters.
module line_mem_ctrl
    import line_mem_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    inout  wire  [LINE_W-1:0] mem_data_ram_bus,
    output logic              mem_ready,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
);

    state_t              state_q, state_d;
    logic                accept, access;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-2:0]   addr_q;
    logic                we_q;
    logic [LINE_W-1:0]   wdata_q, rdata_q;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = mem_addr[0];

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = BUSY;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (!mem_req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt_q  <= CNT_W'(LAT - 1);
            addr_q <= mem_addr[ADDR_W-1:1];
            we_q   <= mem_rw;
            if (mem_rw) begin
                wdata_q <= mem_data_ram_bus;
            end
        end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    line_mem_array #(
        .IDX_W  (ADDR_W - 1),
        .LINE_W (LINE_W),
        .DEPTH  (LINE_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (access & we_q),
        .re    (access & ~we_q),
        .idx   (addr_q),
        .wdata (wdata_q),
        .rdata (rdata_q)
    );

    // Decoded straight from state so reset drops the pulse and the bus at once.
    assign mem_ready        = (state_q == RESP);
    assign mem_data_ram_bus = (state_q == RESP && !we_q) ? rdata_q : 'z;

`ifdef LINE_MEM_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (access) begin
            if (we_q) begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + STAT_W'(1);
            end else begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + STAT_W'(1);
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl: directed table, hand-written corner
// sequences and random traffic against a line-array reference model.
module tb_line_mem_ctrl;

    localparam int LAT = 2;
    localparam int AW  = 10;
    localparam int LW  = 20;
    localparam logic [LW-1:0] PULL = '1;   // value of the bus when nobody drives

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_rw = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic          drv_en = 1'b0;
    logic [LW-1:0] drv_data = '0;
    tri1  [LW-1:0] mem_bus;
    logic          mem_ready;
    logic [15:0]   rd_count, wr_count;

    int checks = 0;
    int failures = 0;
    int mdl_rd = 0;
    int mdl_wr = 0;
    logic [LW-1:0] ref_mem [512];

    assign mem_bus = drv_en ? drv_data : 'z;

    always #5 clk = ~clk;

    line_mem_ctrl #(.LAT(LAT), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req          (mem_req),
        .mem_rw           (mem_rw),
        .mem_addr         (mem_addr),
        .mem_data_ram_bus (mem_bus),
        .mem_ready        (mem_ready),
        .rd_count         (rd_count),
        .wr_count         (wr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 32'hFFFF) ? v : v + 1;
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef LINE_MEM_STATS_EN
        return v;
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic model_complete(input logic rw, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        if (rw) begin
            ref_mem[addr[AW-1:1]] = wd;
            mdl_wr = sat_inc(mdl_wr);
        end else begin
            mdl_rd = sat_inc(mdl_rd);
        end
    endtask

    // Counts rising edges until mem_ready is seen at a falling edge (bounded).
    task automatic wait_pulse(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = mem_ready;
        end
    endtask

    task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                       output logic [LW-1:0] rd);
        int  n;
        bit  seen;
        @(negedge clk);
        mem_req  = 1'b1;
        mem_rw   = rw;
        mem_addr = addr;
        drv_en   = rw;
        drv_data = wd;
        @(posedge clk);
        #1;
        drv_en   = 1'b0;
        mem_rw   = ~rw;
        mem_addr = ~addr;
        wait_pulse(n, seen);
        check("latency", n, LAT);
        rd = mem_bus;
        if (rw) check("no_drive_on_write", mem_bus, PULL);
        mem_req = 1'b0;
        if (seen) model_complete(rw, addr, wd);
        @(negedge clk);
        check("pulse_width", mem_ready, 1'b0);
        check("bus_release", mem_bus, PULL);
    endtask

    task automatic b2b(input logic [AW-1:0] waddr, input logic [LW-1:0] wd, input logic [AW-1:0] raddr);
        int            n;
        bit            seen;
        logic [LW-1:0] exp_d;
        @(negedge clk);
        mem_req  = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = waddr;
        drv_en   = 1'b1;
        drv_data = wd;
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        wait_pulse(n, seen);
        check("b2b_first_latency", n, LAT);
        if (seen) model_complete(1'b1, waddr, wd);
        exp_d    = ref_mem[raddr[AW-1:1]];
        mem_rw   = 1'b0;
        mem_addr = raddr;
        wait_pulse(n, seen);
        check("b2b_spacing", n, LAT + 2);
        check("b2b_rdata", mem_bus, exp_d);
        mem_req = 1'b0;
        if (seen) model_complete(1'b0, raddr, '0);
        @(negedge clk);
        check("b2b_pulse_end", mem_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[10];
        logic [LW-1:0] rd, exp_d, d;
        logic [AW-1:0] a;
        logic          rw;
        int            n;
        bit            seen;

        foreach (ref_mem[i]) ref_mem[i] = '0;

        vecs[0] = '{1'b0, 10'd50,   20'h00000, 20'h00000};
        vecs[1] = '{1'b1, 10'd84,   20'h12C19, 20'h00000};
        vecs[2] = '{1'b0, 10'd85,   20'h00000, 20'h12C19};
        vecs[3] = '{1'b0, 10'd1022, 20'h00000, 20'h00000};
        vecs[4] = '{1'b1, 10'd1023, 20'h5A5A5, 20'h00000};
        vecs[5] = '{1'b0, 10'd1022, 20'h00000, 20'h5A5A5};
        vecs[6] = '{1'b0, 10'd0,    20'h00000, 20'h00000};
        vecs[7] = '{1'b1, 10'd1,    20'h0F0F0, 20'h00000};
        vecs[8] = '{1'b0, 10'd0,    20'h00000, 20'h0F0F0};
        vecs[9] = '{1'b0, 10'd84,   20'h00000, 20'h12C19};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_bus_z", mem_bus, PULL);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_pulse", mem_ready, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].rw) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end
        check("tbl_rd_count", rd_count, exp_cnt(mdl_rd));
        check("tbl_wr_count", wr_count, exp_cnt(mdl_wr));

        b2b(10'd148, 20'h3C0F1, 10'd150);
        b2b(10'd148, 20'h0C3A5, 10'd149);

        txn(1'b1, 10'd223, 20'h11111, rd);
        @(negedge clk);
        mem_req  = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = 10'd223;
        drv_en   = 1'b1;
        drv_data = 20'h22222;
        @(negedge clk);
        mem_req = 1'b0;
        drv_en  = 1'b0;
        seen = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        check("abort_no_pulse", seen, 1'b0);
        check("abort_wr_count", wr_count, exp_cnt(mdl_wr));
        txn(1'b0, 10'd223, '0, rd);
        check("abort_old_data", rd, 20'h11111);

        txn(1'b1, 10'd300, 20'h33333, rd);
        @(negedge clk);
        mem_req  = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = 10'd300;
        drv_en   = 1'b1;
        drv_data = 20'h44444;
        @(negedge clk);
        rst_n   = 1'b0;
        mem_req = 1'b0;
        drv_en  = 1'b0;
        mdl_rd  = 0;
        mdl_wr  = 0;
        #1;
        check("rst_mid_ready", mem_ready, 1'b0);
        @(negedge clk);
        check("rst_mid_bus_z", mem_bus, PULL);
        check("rst_mid_wr_count", wr_count, 0);
        rst_n = 1'b1;
        txn(1'b0, 10'd300, '0, rd);
        check("rst_mid_old_data", rd, 20'h33333);

        @(negedge clk);
        mem_req  = 1'b1;
        mem_rw   = 1'b0;
        mem_addr = 10'd85;
        @(posedge clk);
        #1;
        wait_pulse(n, seen);
        check("async_pulse_seen", seen, 1'b1);
        check("async_pulse_data", mem_bus, 20'h12C19);
        rst_n = 1'b0;
        #1;
        check("async_ready_drop", mem_ready, 1'b0);
        check("async_bus_z", mem_bus, PULL);
        mem_req = 1'b0;
        mdl_rd  = 0;
        mdl_wr  = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = AW'($urandom);
            d  = LW'($urandom);
            exp_d = ref_mem[a[AW-1:1]];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(rw, a, d, rd);
            if (!rw) check($sformatf("rand%0d_rdata", i), rd, exp_d);
        end
        check("final_rd_count", rd_count, exp_cnt(mdl_rd));
        check("final_wr_count", wr_count, exp_cnt(mdl_wr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
